// File: rtl/grf_wb_arbiter_if.sv
// grf_wb_arbiter_if: write-back request bus, reservation port and
// register-file write port of the GRF write-back arbiter.
// Handshake: a request on source i transfers in a cycle where
// req_valid[i] and req_ready[i] are both high; the requester holds
// valid, rw, data and pc stable until that transfer, and req_ready[i]
// is never high while req_valid[i] is low.
interface grf_wb_arbiter_if;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_rw;
    logic [95:0] req_data;
    logic [95:0] req_pc;
    logic        rsv_valid;
    logic [4:0]  rsv_rw;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_wd;
    logic [31:0] rf_pc;
    logic [31:0] busy;

    // Arbiter side.
    modport slave (
        input  req_valid, req_rw, req_data, req_pc, rsv_valid, rsv_rw,
        output req_ready, rf_we, rf_rw, rf_wd, rf_pc, busy
    );

    // Requester / environment side.
    modport master (
        output req_valid, req_rw, req_data, req_pc, rsv_valid, rsv_rw,
        input  req_ready, rf_we, rf_rw, rf_wd, rf_pc, busy
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: arbitrates three write-back sources (0 ALU, 1 load,
// 2 mul/div) onto one register-file write port with a one-cycle
// registered path, and keeps a busy scoreboard of outstanding writes.
// Optional feature: define GRF_WB_RR_EN for round-robin arbitration;
// otherwise fixed priority load > ALU > mul/div.
module grf_wb_arbiter (
    input  logic              clk,
    input  logic              reset,
    grf_wb_arbiter_if.slave   wb
);

    logic [2:0]  grant;
    logic        xfer;
    logic [4:0]  sel_rw;
    logic [31:0] sel_data;
    logic [31:0] sel_pc;

    logic        rf_we_q,  rf_we_d;
    logic [4:0]  rf_rw_q,  rf_rw_d;
    logic [31:0] rf_wd_q,  rf_wd_d;
    logic [31:0] rf_pc_q,  rf_pc_d;
    logic [31:0] busy_q,   busy_d;

`ifdef GRF_WB_RR_EN
    logic [1:0]  ptr_q, ptr_d;

    // Round-robin grant: priority starts at ptr_q and rotates upward.
    always_comb begin
        grant = 3'b000;
        if (!reset) begin
            case (ptr_q)
                2'd1: begin
                    if      (wb.req_valid[1]) grant = 3'b010;
                    else if (wb.req_valid[2]) grant = 3'b100;
                    else if (wb.req_valid[0]) grant = 3'b001;
                end
                2'd2: begin
                    if      (wb.req_valid[2]) grant = 3'b100;
                    else if (wb.req_valid[0]) grant = 3'b001;
                    else if (wb.req_valid[1]) grant = 3'b010;
                end
                default: begin
                    if      (wb.req_valid[0]) grant = 3'b001;
                    else if (wb.req_valid[1]) grant = 3'b010;
                    else if (wb.req_valid[2]) grant = 3'b100;
                end
            endcase
        end
    end

    // Pointer moves to the source after the one just granted, only on a transfer.
    always_comb begin
        ptr_d = ptr_q;
        if      (grant[0]) ptr_d = 2'd1;
        else if (grant[1]) ptr_d = 2'd2;
        else if (grant[2]) ptr_d = 2'd0;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 2'd0;
        else       ptr_q <= ptr_d;
    end
`else
    // Fixed-priority grant: load first, then ALU, then mul/div.
    always_comb begin
        grant = 3'b000;
        if (!reset) begin
            if      (wb.req_valid[1]) grant = 3'b010;
            else if (wb.req_valid[0]) grant = 3'b001;
            else if (wb.req_valid[2]) grant = 3'b100;
        end
    end
`endif

    assign xfer = |grant;

    // Select the granted source's register, data and PC.
    always_comb begin
        sel_rw   = wb.req_rw[4:0];
        sel_data = wb.req_data[31:0];
        sel_pc   = wb.req_pc[31:0];
        if (grant[1]) begin
            sel_rw   = wb.req_rw[9:5];
            sel_data = wb.req_data[63:32];
            sel_pc   = wb.req_pc[63:32];
        end else if (grant[2]) begin
            sel_rw   = wb.req_rw[14:10];
            sel_data = wb.req_data[95:64];
            sel_pc   = wb.req_pc[95:64];
        end
    end

    // Next write-port state: capture on transfer, suppress the enable for r0.
    always_comb begin
        rf_we_d = xfer && (sel_rw != 5'd0);
        rf_rw_d = rf_rw_q;
        rf_wd_d = rf_wd_q;
        rf_pc_d = rf_pc_q;
        if (xfer) begin
            rf_rw_d = sel_rw;
            rf_wd_d = sel_data;
            rf_pc_d = sel_pc;
        end
    end

    // Next scoreboard: clear on write, then set on reservation so set wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) busy_d[rf_rw_q] = 1'b0;
        if (wb.rsv_valid && (wb.rsv_rw != 5'd0)) busy_d[wb.rsv_rw] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Write-port and scoreboard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q <= 1'b0;
            rf_rw_q <= 5'd0;
            rf_wd_q <= 32'd0;
            rf_pc_q <= 32'd0;
            busy_q  <= 32'd0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_rw_q <= rf_rw_d;
            rf_wd_q <= rf_wd_d;
            rf_pc_q <= rf_pc_d;
            busy_q  <= busy_d;
        end
    end

    assign wb.req_ready = grant;
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_rw     = rf_rw_q;
    assign wb.rf_wd     = rf_wd_q;
    assign wb.rf_pc     = rf_pc_q;
    assign wb.busy      = busy_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: directed bench for grf_wb_arbiter. Inputs change on
// the falling edge; outputs are sampled 1 time unit after that.
module tb_grf_wb_arbiter;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    grf_wb_arbiter_if wb ();

    grf_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic clear_reqs();
        wb.req_valid = 3'b000;
        wb.rsv_valid = 1'b0;
        wb.rsv_rw    = 5'd0;
    endtask

    task automatic set_req(input int idx, input logic [4:0] rw,
                           input logic [31:0] d, input logic [31:0] pc);
        wb.req_valid[idx]      = 1'b1;
        wb.req_rw[idx*5 +: 5]  = rw;
        wb.req_data[idx*32 +: 32] = d;
        wb.req_pc[idx*32 +: 32]   = pc;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_reqs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reset state, and ready held low while reset is high.
    task automatic test_reset();
        @(negedge clk);
        wb.req_valid = 3'b111;
        #1;
        vectors++; if (wb.req_ready !== 3'b000) begin miscompares++; $display("FAIL reset_ready got=%b exp=000", wb.req_ready); end
        vectors++; if (wb.rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we got=%b exp=0", wb.rf_we); end
        vectors++; if (wb.rf_rw !== 5'd0) begin miscompares++; $display("FAIL reset_rf_rw got=%0d exp=0", wb.rf_rw); end
        vectors++; if (wb.rf_wd !== 32'd0) begin miscompares++; $display("FAIL reset_rf_wd got=%h exp=0", wb.rf_wd); end
        vectors++; if (wb.rf_pc !== 32'd0) begin miscompares++; $display("FAIL reset_rf_pc got=%h exp=0", wb.rf_pc); end
        vectors++; if (wb.busy !== 32'd0) begin miscompares++; $display("FAIL reset_busy got=%h exp=0", wb.busy); end
        clear_reqs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Single write from ALU source after reset.
    task automatic test_basic_write();
        apply_reset();
        set_req(0, 5'd5, 32'h1234_5678, 32'h0000_3000);
        #1;
        vectors++; if (wb.req_ready !== 3'b001) begin miscompares++; $display("FAIL basic_ready got=%b exp=001", wb.req_ready); end
        @(negedge clk);
        clear_reqs();
        #1;
        vectors++; if (wb.rf_we !== 1'b1) begin miscompares++; $display("FAIL basic_rf_we got=%b exp=1", wb.rf_we); end
        vectors++; if (wb.rf_rw !== 5'd5) begin miscompares++; $display("FAIL basic_rf_rw got=%0d exp=5", wb.rf_rw); end
        vectors++; if (wb.rf_wd !== 32'h1234_5678) begin miscompares++; $display("FAIL basic_rf_wd got=%h exp=12345678", wb.rf_wd); end
        vectors++; if (wb.rf_pc !== 32'h0000_3000) begin miscompares++; $display("FAIL basic_rf_pc got=%h exp=00003000", wb.rf_pc); end
        @(negedge clk);
        #1;
        vectors++; if (wb.rf_we !== 1'b0) begin miscompares++; $display("FAIL basic_idle_we got=%b exp=0", wb.rf_we); end
        vectors++; if (wb.rf_rw !== 5'd5) begin miscompares++; $display("FAIL basic_hold_rw got=%0d exp=5", wb.rf_rw); end
        vectors++; if (wb.rf_wd !== 32'h1234_5678) begin miscompares++; $display("FAIL basic_hold_wd got=%h exp=12345678", wb.rf_wd); end
    endtask

    // All three sources valid; each drops after its transfer.
    task automatic test_all_valid();
        logic [2:0] exp_g [3];
        logic [4:0] exp_rw [3];
`ifdef GRF_WB_RR_EN
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        exp_rw[0] = 5'd11; exp_rw[1] = 5'd12; exp_rw[2] = 5'd13;
`else
        exp_g[0] = 3'b010; exp_g[1] = 3'b001; exp_g[2] = 3'b100;
        exp_rw[0] = 5'd12; exp_rw[1] = 5'd11; exp_rw[2] = 5'd13;
`endif
        apply_reset();
        set_req(0, 5'd11, 32'h0000_00A0, 32'h0000_1000);
        set_req(1, 5'd12, 32'h0000_00A1, 32'h0000_1004);
        set_req(2, 5'd13, 32'h0000_00A2, 32'h0000_1008);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (wb.req_ready !== exp_g[c]) begin miscompares++; $display("FAIL all_valid_grant%0d got=%b exp=%b", c, wb.req_ready, exp_g[c]); end
            @(negedge clk);
            wb.req_valid = wb.req_valid & ~exp_g[c];
            #1;
            vectors++; if (wb.rf_we !== 1'b1) begin miscompares++; $display("FAIL all_valid_we%0d got=%b exp=1", c, wb.rf_we); end
            vectors++; if (wb.rf_rw !== exp_rw[c]) begin miscompares++; $display("FAIL all_valid_rw%0d got=%0d exp=%0d", c, wb.rf_rw, exp_rw[c]); end
        end
        vectors++; if (wb.req_ready !== 3'b000) begin miscompares++; $display("FAIL all_valid_drained got=%b exp=000", wb.req_ready); end
    endtask

    // One write per cycle from the same source.
    task automatic test_back_to_back();
        @(negedge clk);
        clear_reqs();
        set_req(0, 5'd1, 32'h0000_0111, 32'h0000_0010);
        #1;
        vectors++; if (wb.req_ready !== 3'b001) begin miscompares++; $display("FAIL b2b_ready0 got=%b exp=001", wb.req_ready); end
        @(negedge clk);
        set_req(0, 5'd2, 32'h0000_0222, 32'h0000_0014);
        #1;
        vectors++; if (wb.req_ready !== 3'b001) begin miscompares++; $display("FAIL b2b_ready1 got=%b exp=001", wb.req_ready); end
        vectors++; if (wb.rf_rw !== 5'd1) begin miscompares++; $display("FAIL b2b_rw0 got=%0d exp=1", wb.rf_rw); end
        vectors++; if (wb.rf_wd !== 32'h0000_0111) begin miscompares++; $display("FAIL b2b_wd0 got=%h exp=00000111", wb.rf_wd); end
        @(negedge clk);
        clear_reqs();
        #1;
        vectors++; if (wb.rf_we !== 1'b1) begin miscompares++; $display("FAIL b2b_we1 got=%b exp=1", wb.rf_we); end
        vectors++; if (wb.rf_rw !== 5'd2) begin miscompares++; $display("FAIL b2b_rw1 got=%0d exp=2", wb.rf_rw); end
        vectors++; if (wb.rf_pc !== 32'h0000_0014) begin miscompares++; $display("FAIL b2b_pc1 got=%h exp=00000014", wb.rf_pc); end
    endtask

    // Write to r0 is consumed without a write enable or busy change.
    task automatic test_r0_write();
        @(negedge clk);
        clear_reqs();
        wb.rsv_valid = 1'b1;
        wb.rsv_rw    = 5'd3;
        @(negedge clk);
        wb.rsv_valid = 1'b0;
        set_req(2, 5'd0, 32'hFFFF_FFFF, 32'h0000_4000);
        #1;
        vectors++; if (wb.busy !== 32'h0000_0008) begin miscompares++; $display("FAIL r0_busy_pre got=%h exp=00000008", wb.busy); end
        vectors++; if (wb.req_ready !== 3'b100) begin miscompares++; $display("FAIL r0_ready got=%b exp=100", wb.req_ready); end
        @(negedge clk);
        clear_reqs();
        #1;
        vectors++; if (wb.rf_we !== 1'b0) begin miscompares++; $display("FAIL r0_rf_we got=%b exp=0", wb.rf_we); end
        vectors++; if (wb.busy !== 32'h0000_0008) begin miscompares++; $display("FAIL r0_busy_post got=%h exp=00000008", wb.busy); end
        set_req(0, 5'd3, 32'h0000_0333, 32'h0000_4004);
        @(negedge clk);
        clear_reqs();
        #1;
        vectors++; if (wb.rf_we !== 1'b1) begin miscompares++; $display("FAIL r3_rf_we got=%b exp=1", wb.rf_we); end
        vectors++; if (wb.busy !== 32'h0000_0008) begin miscompares++; $display("FAIL r3_busy_wecycle got=%h exp=00000008", wb.busy); end
        @(negedge clk);
        #1;
        vectors++; if (wb.busy !== 32'h0000_0000) begin miscompares++; $display("FAIL r3_busy_cleared got=%h exp=00000000", wb.busy); end
    endtask

    // Reservation / write interplay on r7, set-wins, distinct regs, r0.
    task automatic test_scoreboard();
        @(negedge clk);
        clear_reqs();
        wb.rsv_valid = 1'b1;
        wb.rsv_rw    = 5'd7;
        @(negedge clk);
        wb.rsv_valid = 1'b0;
        set_req(1, 5'd7, 32'hCAFE_0007, 32'h0000_5000);
        #1;
        vectors++; if (wb.busy !== 32'h0000_0080) begin miscompares++; $display("FAIL sb_busy_set got=%h exp=00000080", wb.busy); end
        vectors++; if (wb.req_ready !== 3'b010) begin miscompares++; $display("FAIL sb_ready got=%b exp=010", wb.req_ready); end
        @(negedge clk);
        clear_reqs();
        #1;
        vectors++; if (wb.rf_we !== 1'b1) begin miscompares++; $display("FAIL sb_rf_we got=%b exp=1", wb.rf_we); end
        vectors++; if (wb.rf_rw !== 5'd7) begin miscompares++; $display("FAIL sb_rf_rw got=%0d exp=7", wb.rf_rw); end
        vectors++; if (wb.busy !== 32'h0000_0080) begin miscompares++; $display("FAIL sb_busy_wecycle got=%h exp=00000080", wb.busy); end
        @(negedge clk);
        #1;
        vectors++; if (wb.busy !== 32'h0000_0000) begin miscompares++; $display("FAIL sb_busy_clear got=%h exp=00000000", wb.busy); end
        // new reservation of r7 in the same cycle as its write
        set_req(1, 5'd7, 32'hCAFE_0017, 32'h0000_5004);
        @(negedge clk);
        clear_reqs();
        wb.rsv_valid = 1'b1;
        wb.rsv_rw    = 5'd7;
        #1;
        vectors++; if (wb.rf_we !== 1'b1) begin miscompares++; $display("FAIL sb_coinc_we got=%b exp=1", wb.rf_we); end
        @(negedge clk);
        wb.rsv_valid = 1'b0;
        #1;
        vectors++; if (wb.busy !== 32'h0000_0080) begin miscompares++; $display("FAIL sb_set_wins got=%h exp=00000080", wb.busy); end
        // clear r7 while reserving r9
        set_req(1, 5'd7, 32'hCAFE_0027, 32'h0000_5008);
        @(negedge clk);
        clear_reqs();
        wb.rsv_valid = 1'b1;
        wb.rsv_rw    = 5'd9;
        @(negedge clk);
        wb.rsv_rw    = 5'd0;
        #1;
        vectors++; if (wb.busy !== 32'h0000_0200) begin miscompares++; $display("FAIL sb_set_clear_diff got=%h exp=00000200", wb.busy); end
        // reserving r0 never sets busy[0]
        @(negedge clk);
        wb.rsv_valid = 1'b0;
        #1;
        vectors++; if (wb.busy !== 32'h0000_0200) begin miscompares++; $display("FAIL sb_r0_rsv got=%h exp=00000200", wb.busy); end
    endtask

    // Reset with a request pending: dropped, no write, busy cleared.
    task automatic test_reset_in_flight();
        @(negedge clk);
        clear_reqs();
        set_req(0, 5'd4, 32'h0000_DEAD, 32'h0000_6000);
        reset = 1'b1;
        #1;
        vectors++; if (wb.req_ready !== 3'b000) begin miscompares++; $display("FAIL rif_ready got=%b exp=000", wb.req_ready); end
        @(negedge clk);
        #1;
        vectors++; if (wb.rf_we !== 1'b0) begin miscompares++; $display("FAIL rif_rf_we got=%b exp=0", wb.rf_we); end
        vectors++; if (wb.busy !== 32'h0000_0000) begin miscompares++; $display("FAIL rif_busy got=%h exp=00000000", wb.busy); end
        vectors++; if (wb.req_ready !== 3'b000) begin miscompares++; $display("FAIL rif_ready_held got=%b exp=000", wb.req_ready); end
        vectors++; if (wb.rf_rw !== 5'd0) begin miscompares++; $display("FAIL rif_rf_rw got=%0d exp=0", wb.rf_rw); end
        reset = 1'b0;
        clear_reqs();
        @(negedge clk);
        #1;
        vectors++; if (wb.rf_we !== 1'b0) begin miscompares++; $display("FAIL rif_no_write got=%b exp=0", wb.rf_we); end
    endtask

    // Sequence and final report
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset        = 1'b1;
        wb.req_valid = 3'b000;
        wb.req_rw    = '0;
        wb.req_data  = '0;
        wb.req_pc    = '0;
        wb.rsv_valid = 1'b0;
        wb.rsv_rw    = 5'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic_write();
        test_all_valid();
        test_back_to_back();
        test_r0_write();
        test_scoreboard();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 SHALL have input clk, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have input req_valid, 3 bits: per-source write-back request. Source 0 is ALU, 1 is load, 2 is mul/div.
REQ-004 SHALL have output req_ready, 3 bits: per-source grant; at most one bit high per cycle.
REQ-005 SHALL have input req_rw, 15 bits: destination register of source i at bits [5i+4:5i].
REQ-006 SHALL have input req_data, 96 bits: write data of source i at bits [32i+31:32i].
REQ-007 SHALL have input req_pc, 96 bits: instruction PC of source i at bits [32i+31:32i].
REQ-008 SHALL have input rsv_valid, 1 bit: the issue stage reserves a destination register.
REQ-009 SHALL have input rsv_rw, 5 bits: the register being reserved.
REQ-010 SHALL have output rf_we, 1 bit: write enable to the register-file write port.
REQ-011 SHALL have output rf_rw, 5 bits: register-file write address.
REQ-012 SHALL have output rf_wd, 32 bits: register-file write data.
REQ-013 SHALL have output rf_pc, 32 bits: PC of the write, for trace.
REQ-014 SHALL have output busy, 32 bits: scoreboard; bit r high means a write to r is outstanding.

Function
REQ-015 SHALL complete a transfer on source i in a cycle where req_valid[i] and req_ready[i] are both high. A requester holds valid, rw, data and pc stable until its transfer completes.
REQ-016 SHALL drive req_ready combinationally from the current req_valid and the arbitration state. req_ready[i] is never high while req_valid[i] is low.
REQ-017 SHALL grant exactly one valid source when any req_valid bit is high. Grant order is per REQ-027/REQ-028.
REQ-018 SHALL register the granted request onto rf_rw, rf_wd and rf_pc one cycle after the transfer. Latency is exactly 1 cycle, throughput is 1 write per cycle.
REQ-019 SHALL set rf_we high in the cycle after a transfer, unless the transferred rw is 0. A write to register 0 is accepted and consumed but rf_we stays 0.
REQ-020 SHALL hold rf_we low in any cycle not preceded by a transfer. rf_rw, rf_wd and rf_pc hold their last values.
REQ-021 SHALL set busy[rsv_rw] at the clock edge when rsv_valid is high and rsv_rw is not 0.
REQ-022 SHALL clear busy[rf_rw] at the clock edge when rf_we is high.
REQ-023 SHALL keep busy set when a set and a clear of the same register occur in the same cycle (set wins). Sets and clears of different registers in the same cycle both take effect.
REQ-024 SHALL hold busy[0] at 0 at all times.

Reset
REQ-025 SHALL, while reset is high at a clock edge, force the following to 0: rf_we, rf_rw, rf_wd, rf_pc, busy and the round-robin pointer.
REQ-026 SHALL hold req_ready at 0 in any cycle where reset is high. A request in flight is dropped without a write, and requesters re-present it after reset.

Configuration
REQ-027 SHALL, when macro GRF_WB_RR_EN is defined, arbitrate round-robin. After a grant to source i, priority order starts at source (i+1) mod 3; the pointer updates only on a transfer.
REQ-028 SHALL, when GRF_WB_RR_EN is undefined, use fixed priority: source 1 (load) over source 0 over source 2. The pointer is not implemented.

Verification
REQ-029 SHALL cover this case: after reset, source 0 presents rw=5, data=0x12345678, pc=0x3000. Required: req_ready=001, then next cycle rf_we=1, rf_rw=5, rf_wd=0x12345678, rf_pc=0x3000.
REQ-030 SHALL cover this case: all three sources valid for 3 cycles. With GRF_WB_RR_EN, grants are 0,1,2 in order. Without it, the first grant is source 1.
REQ-031 SHALL cover this case: source 2 writes rw=0, data=0xFFFFFFFF. Required: transfer completes, rf_we stays 0 next cycle, busy unchanged.
REQ-032 SHALL cover this case: reserve r7 via rsv_valid, then write r7 from source 1. Required: busy[7]=1 until the rf_we cycle, then 0. A new reservation of r7 coinciding with the write leaves busy[7]=1.
REQ-033 SHALL cover this case: assert reset while source 0 is valid with a pending grant. Required: req_ready=000, rf_we=0, busy=0 the next cycle, and no write issued for that request.
